// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_pkg
// Brief   : Shared types and constants for the instruction-fetch stage.
// Rev     : 1.0
// ============================================================================
package mips_pkg;

    localparam int PC_W = 32;

    // Bit positions inside the jump_i control vector
    localparam int JUMP_J    = 0;
    localparam int JUMP_JR   = 1;
    localparam int JUMP_LINK = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : fetch_unit_if
// Brief     : imem request/response and decode-side handshake of the fetch stage.
// Rev       : 1.0
// ============================================================================
interface fetch_unit_if;
    import mips_pkg::*;

    logic            imem_req_o;
    logic [PC_W-1:0] imem_addr_o;
    logic            imem_valid_i;
    logic [31:0]     imem_rdata_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [31:0]     instr_o;
    logic [5:0]      op_o;
    logic [5:0]      funct_o;
    logic [PC_W-1:0] pc_o;
    logic [PC_W-1:0] pc_plus4_o;
    logic            pc_src_i;
    logic [2:0]      jump_i;
    logic [PC_W-1:0] jr_target_i;
    logic            fault_o;
    logic [31:0]     instr_count_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, op_o, funct_o,
               pc_o, pc_plus4_o, fault_o, instr_count_o,
        input  imem_valid_i, imem_rdata_i, instr_ready_i, pc_src_i, jump_i,
               jr_target_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, op_o, funct_o,
               pc_o, pc_plus4_o, fault_o, instr_count_o,
        output imem_valid_i, imem_rdata_i, instr_ready_i, pc_src_i, jump_i,
               jr_target_i
    );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit_npc_sel.sv
`default_nettype none
// ============================================================================
// Module : npc_sel
// Brief  : Combinational next-PC mux: JR > J > taken branch > sequential.
// Rev    : 1.0
// ============================================================================
module npc_sel
    import mips_pkg::*;
(
    input  wire logic [PC_W-1:0] pc_plus4_i,
    input  wire logic [31:0]     instr_i,
    input  wire logic            pc_src_i,
    input  wire logic [1:0]      jump_i,
    input  wire logic [PC_W-1:0] jr_target_i,
    output logic      [PC_W-1:0] npc_o
);

    logic [PC_W-1:0] w_j_target;
    logic [PC_W-1:0] w_br_target;

    assign w_j_target  = {pc_plus4_i[31:28], instr_i[25:0], 2'b00};
    assign w_br_target = pc_plus4_i + {{14{instr_i[15]}}, instr_i[15:0], 2'b00};

    always_comb begin
        npc_o = pc_plus4_i;
        if (jump_i[JUMP_JR] === 1'b1) begin
            npc_o = jr_target_i;
        end else if (jump_i[JUMP_J] === 1'b1) begin
            npc_o = w_j_target;
        end else if (pc_src_i === 1'b1) begin
            npc_o = w_br_target;
        end
    end

endmodule : npc_sel
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit
// Brief  : Multi-cycle instruction fetch: owns the PC, holds each word until
//          accepted by decode, then redirects via npc_sel.
// Rev    : 1.0
// ============================================================================
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
)(
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    fetch_unit_if.master  bus
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     count_q, count_d;
    logic            imem_req_q, imem_req_d;
    logic            instr_valid_q, instr_valid_d;
    logic            fault_q, fault_d;

    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_npc;
    logic            w_unused_link;

    assign w_pc_plus4    = pc_q + 32'd4;
    // The link bit is consumed by the register-file write path, not here
    assign w_unused_link = bus.jump_i[JUMP_LINK];

    npc_sel u_npc_sel (
        .pc_plus4_i  (w_pc_plus4),
        .instr_i     (instr_q),
        .pc_src_i    (bus.pc_src_i),
        .jump_i      (bus.jump_i[JUMP_JR:JUMP_J]),
        .jr_target_i (bus.jr_target_i),
        .npc_o       (w_npc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.imem_valid_i) begin
                    instr_d = bus.imem_rdata_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.instr_ready_i) begin
                    // pc_o exposes the offending target even when it faults
                    pc_d = w_npc;
                    if (w_npc[1:0] == 2'b00) begin
                        count_d = count_q + 32'd1;
                        state_d = REQ;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
        imem_req_d    = (state_d == REQ);
        instr_valid_d = (state_d == ISSUE);
        fault_d       = (state_d == FAULT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            count_q       <= 32'd0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            count_q       <= count_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.imem_req_o    = imem_req_q;
    assign bus.imem_addr_o   = pc_q;
    assign bus.instr_valid_o = instr_valid_q;
    assign bus.instr_o       = instr_q;
    assign bus.op_o          = instr_q[31:26];
    assign bus.funct_o       = instr_q[5:0];
    assign bus.pc_o          = pc_q;
    assign bus.pc_plus4_o    = w_pc_plus4;
    assign bus.fault_o       = fault_q;
    assign bus.instr_count_o = count_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Directed self-checking bench for fetch_unit with an expected-fetch queue.
// Rev    : 1.0
// ============================================================================
module tb_fetch_unit;
    import mips_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_count = 32'd0;
    exp_t        sb[$];

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, bus.imem_req_o},    32'd0);
        chk({tag, "_addr"},  bus.imem_addr_o,            32'd0);
        chk({tag, "_valid"}, {31'd0, bus.instr_valid_o}, 32'd0);
        chk({tag, "_instr"}, bus.instr_o,                32'd0);
        chk({tag, "_op"},    {26'd0, bus.op_o},          32'd0);
        chk({tag, "_funct"}, {26'd0, bus.funct_o},       32'd0);
        chk({tag, "_pc"},    bus.pc_o,                   32'd0);
        chk({tag, "_pc4"},   bus.pc_plus4_o,             32'd4);
        chk({tag, "_fault"}, {31'd0, bus.fault_o},       32'd0);
        chk({tag, "_count"}, bus.instr_count_o,          32'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.imem_valid_i  = 1'b0;
        bus.instr_ready_i = 1'b0;
        repeat (n) @(negedge clk);
        chk_reset_outputs("in_reset");
        rst = 1'b0;
        exp_count = 32'd0;
        sb.delete();
        #1;
        chk("rel_cycle1_req", {31'd0, bus.imem_req_o}, 32'd0);
        chk("rel_cycle1_pc",  bus.pc_o, 32'd0);
        @(negedge clk);
        chk("rel_cycle2_req", {31'd0, bus.imem_req_o}, 32'd1);
        chk("rel_cycle2_addr", bus.imem_addr_o, 32'd0);
    endtask

    task automatic serve(input logic [31:0] data, input logic [31:0] addr);
        exp_t e;
        int   k = 0;
        while (bus.imem_req_o !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_seen", {31'd0, bus.imem_req_o}, 32'd1);
        chk("imem_addr", bus.imem_addr_o, addr);
        sb.push_back('{instr: data, pc: addr});
        bus.imem_valid_i = 1'b1;
        bus.imem_rdata_i = data;
        @(negedge clk);
        bus.imem_valid_i = 1'b0;
        bus.imem_rdata_i = $urandom;
        chk("instr_valid", {31'd0, bus.instr_valid_o}, 32'd1);
        chk("issue_req_low", {31'd0, bus.imem_req_o}, 32'd0);
        chk("sb_nonempty", sb.size(), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("instr_o", bus.instr_o, e.instr);
            chk("op_o",    {26'd0, bus.op_o},    {26'd0, e.instr[31:26]});
            chk("funct_o", {26'd0, bus.funct_o}, {26'd0, e.instr[5:0]});
            chk("pc_o",    bus.pc_o, e.pc);
            chk("pc_plus4_o", bus.pc_plus4_o, e.pc + 32'd4);
        end
    endtask

    task automatic accept(input logic [2:0] j, input logic ps, input logic [31:0] jr,
                          input logic [31:0] exp_npc, input bit exp_fault);
        bus.instr_ready_i = 1'b1;
        bus.jump_i        = j;
        bus.pc_src_i      = ps;
        bus.jr_target_i   = jr;
        @(negedge clk);
        bus.instr_ready_i = 1'b0;
        bus.jump_i        = 3'($urandom);
        bus.pc_src_i      = 1'($urandom);
        bus.jr_target_i   = $urandom;
        if (!exp_fault) exp_count = exp_count + 32'd1;
        chk("post_valid", {31'd0, bus.instr_valid_o}, 32'd0);
        chk("post_req",   {31'd0, bus.imem_req_o}, exp_fault ? 32'd0 : 32'd1);
        chk("post_npc",   bus.pc_o, exp_npc);
        chk("post_addr",  bus.imem_addr_o, exp_npc);
        chk("post_fault", {31'd0, bus.fault_o}, {31'd0, exp_fault});
        chk("post_count", bus.instr_count_o, exp_count);
    endtask

    initial begin
        bus.imem_valid_i  = 1'b0;
        bus.imem_rdata_i  = 32'd0;
        bus.instr_ready_i = 1'b0;
        bus.pc_src_i      = 1'b0;
        bus.jump_i        = 3'd0;
        bus.jr_target_i   = 32'd0;

        // Reset and first sequential fetch
        do_reset(3);
        serve(32'h2008_0005, 32'h0);
        chk("addi_op", {26'd0, bus.op_o}, 32'h08);
        accept(3'b000, 1'b0, 32'h0, 32'h4, 1'b0);

        // Jump, branch (backward to self), priority and sequential
        do_reset(2);
        serve(32'h0800_0040, 32'h0);
        accept(3'b001, 1'b0, 32'h0, 32'h100, 1'b0);
        serve(32'h0800_0004, 32'h100);
        accept(3'b001, 1'b0, 32'h0, 32'h10, 1'b0);
        serve(32'h1000_FFFF, 32'h10);
        accept(3'b000, 1'b1, 32'h0, 32'h10, 1'b0);
        serve(32'h0000_0000, 32'h10);
        accept(3'b111, 1'b1, 32'h40, 32'h40, 1'b0);
        serve(32'h1000_0003, 32'h40);
        accept(3'b000, 1'b1, 32'h0, 32'h50, 1'b0);
        serve(32'h2400_0000, 32'h50);
        accept(3'b000, 1'b0, 32'hFFFF_FFF0, 32'h54, 1'b0);

        // Misaligned JR target -> sticky fault
        serve(32'h0000_0008, 32'h54);
        accept(3'b010, 1'b0, 32'h202, 32'h202, 1'b1);
        for (int i = 0; i < 12; i++) begin
            bus.imem_valid_i  = 1'($urandom);
            bus.instr_ready_i = 1'($urandom);
            @(negedge clk);
            chk("fault_hold_req",   {31'd0, bus.imem_req_o}, 32'd0);
            chk("fault_hold_flag",  {31'd0, bus.fault_o}, 32'd1);
            chk("fault_hold_valid", {31'd0, bus.instr_valid_o}, 32'd0);
            chk("fault_hold_count", bus.instr_count_o, 32'd6);
            chk("fault_hold_pc",    bus.pc_o, 32'h202);
        end
        do_reset(2);

        // Back-pressure with stray imem_valid pulses
        serve(32'hAC0A_0010, 32'h0);
        for (int i = 0; i < 5; i++) begin
            bus.imem_valid_i = 1'b1;
            bus.imem_rdata_i = $urandom;
            @(negedge clk);
            chk("bp_instr", bus.instr_o, 32'hAC0A_0010);
            chk("bp_pc",    bus.pc_o, 32'h0);
            chk("bp_req",   {31'd0, bus.imem_req_o}, 32'd0);
            chk("bp_valid", {31'd0, bus.instr_valid_o}, 32'd1);
        end
        bus.imem_valid_i = 1'b0;
        accept(3'b000, 1'b0, 32'h0, 32'h4, 1'b0);

        // Reset mid-REQ with a coincident and a late imem_valid
        rst = 1'b1;
        bus.imem_valid_i = 1'b1;
        bus.imem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk_reset_outputs("midreq_reset");
        rst = 1'b0;
        exp_count = 32'd0;
        @(negedge clk);
        chk("late_valid_req",   {31'd0, bus.imem_req_o}, 32'd1);
        chk("late_valid_instr", bus.instr_o, 32'd0);
        chk("late_valid_valid", {31'd0, bus.instr_valid_o}, 32'd0);
        bus.imem_valid_i = 1'b0;

        // Counter wrap
        serve(32'h0000_0020, 32'h0);
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        #1;
        chk("count_preload", bus.instr_count_o, 32'hFFFF_FFFF);
        exp_count = 32'hFFFF_FFFF;
        accept(3'b000, 1'b0, 32'h0, 32'h4, 1'b0);
        chk("count_wrapped", bus.instr_count_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule : tb_fetch_unit
`default_nettype wire
